glitch_filter_n: RTL and testbench

// - Multi-channel input conditioner: synchronises WIDTH asynchronous inputs and

---
 rtl/glitch_filter_n.sv | 136 +++++++++++++
 tb/tb_glitch_filter_n.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/glitch_filter_n.sv
`default_nettype none
// ============================================================================
// Module      : glitch_filter_n
// Description : Multi-channel input conditioner. Each of WIDTH asynchronous
//               inputs is synchronised through SYNC_STAGES flops, then only
//               accepted as a new level after FILTER_CYCLES consecutive
//               differing samples. Shorter pulses are rejected and counted.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               in_raw     - raw asynchronous inputs, one bit per channel
//               enable     - 1 = filtering active, 0 = outputs frozen
//               clr_cnt    - synchronous clear of glitch_cnt (wins over +)
//               out_filt   - filtered, registered level per channel
//               rise       - one-cycle strobe, out_filt bit went 0->1
//               fall       - one-cycle strobe, out_filt bit went 1->0
//               glitch_cnt - saturating count of rejected pulses
// Revision    : 1.0 - initial release
// ============================================================================
module glitch_filter_n #(
   parameter int WIDTH         = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int SYNC_STAGES   = 2,
   parameter bit RESET_VAL     = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_raw,
   input  logic             enable,
   input  logic             clr_cnt,
   output logic [WIDTH-1:0] out_filt,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [7:0]       glitch_cnt
);

   localparam int               c_CNT_W    = $clog2(FILTER_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_CYCLES - 1);
   localparam logic [31:0]      c_GLITCH_MAX = 32'd255;

   // ------------------------------------------------------------------------
   // Synchroniser: stage 0 samples in_raw, the last stage feeds the filter.
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0]                  w_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{{WIDTH{RESET_VAL}}}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], in_raw};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   // ------------------------------------------------------------------------
   // Per-channel qualification counter, filtered level and edge strobes.
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] w_reject;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic [c_CNT_W-1:0] r_cnt;
      logic               r_out;
      logic               r_rise;
      logic               r_fall;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt  <= '0;
            r_out  <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
         end else if (!enable) begin
            // Frozen: any partial qualification is discarded so that a full
            // FILTER_CYCLES run is needed after re-enable.
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
         end else if (w_s[i] != r_out) begin
            if (r_cnt == c_CNT_LAST) begin
               r_out  <= w_s[i];
               r_cnt  <= '0;
               r_rise <= w_s[i];
               r_fall <= ~w_s[i];
            end else begin
               r_cnt  <= r_cnt + c_CNT_W'(1);
               r_rise <= 1'b0;
               r_fall <= 1'b0;
            end
         end else begin
            // Sample returned to the current level: any count in progress
            // was a glitch (flagged via w_reject) and is abandoned.
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
         end
      end

      assign w_reject[i] = enable && (w_s[i] == r_out) && (r_cnt != '0);
      assign out_filt[i] = r_out;
      assign rise[i]     = r_rise;
      assign fall[i]     = r_fall;
   end

   // ------------------------------------------------------------------------
   // Glitch counter: several channels may reject on the same edge, so the
   // increment is a population count, then saturated at 255.
   // ------------------------------------------------------------------------
   logic [7:0]  r_glitch;
   logic [31:0] w_nrej;
   logic [31:0] w_total;

   always_comb begin
      w_nrej = '0;
      for (int k = 0; k < WIDTH; k++) begin
         w_nrej = w_nrej + 32'(w_reject[k]);
      end
      w_total = 32'(r_glitch) + w_nrej;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_glitch <= 8'd0;
      end else if (clr_cnt) begin
         r_glitch <= 8'd0;
      end else if (w_total > c_GLITCH_MAX) begin
         r_glitch <= 8'd255;
      end else begin
         r_glitch <= w_total[7:0];
      end
   end

   assign glitch_cnt = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_glitch_filter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_glitch_filter_n
// Description : Directed self-checking bench for glitch_filter_n with the
//               default parameters (WIDTH=2, FILTER_CYCLES=4, SYNC_STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glitch_filter_n;

   logic       clk;
   logic       rst_n;
   logic [1:0] in_raw;
   logic       enable;
   logic       clr_cnt;
   logic [1:0] out_filt;
   logic [1:0] rise;
   logic [1:0] fall;
   logic [7:0] glitch_cnt;

   int total = 0;
   int bad   = 0;

   glitch_filter_n #(
      .WIDTH         (2),
      .FILTER_CYCLES (4),
      .SYNC_STAGES   (2),
      .RESET_VAL     (1'b0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_raw     (in_raw),
      .enable     (enable),
      .clr_cnt    (clr_cnt),
      .out_filt   (out_filt),
      .rise       (rise),
      .fall       (fall),
      .glitch_cnt (glitch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle 1 time unit so outputs are sampled and
   // inputs driven away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      in_raw  = 2'b11;
      enable  = 1'b1;
      clr_cnt = 1'b0;
      #1;
      total++; if (out_filt !== 2'b00) begin bad++; $display("FAIL rst_out got=%b want=00", out_filt); end
      total++; if (rise !== 2'b00) begin bad++; $display("FAIL rst_rise got=%b want=00", rise); end
      total++; if (fall !== 2'b00) begin bad++; $display("FAIL rst_fall got=%b want=00", fall); end
      total++; if (glitch_cnt !== 8'd0) begin bad++; $display("FAIL rst_gcnt got=%0d want=0", glitch_cnt); end
      tick(); tick();
      in_raw = 2'b00;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) tick();
   endtask

   // Step on ch0: accepted on edge 6, rise for that cycle only.
   task automatic test_latency();
      in_raw = 2'b01;
      for (int n = 1; n <= 7; n++) begin
         tick();
         total++;
         if (out_filt[0] !== (n >= 6)) begin
            bad++; $display("FAIL lat_out e%0d got=%b want=%b", n, out_filt[0], (n >= 6));
         end
         total++;
         if (rise !== ((n == 6) ? 2'b01 : 2'b00)) begin
            bad++; $display("FAIL lat_rise e%0d got=%b want=%b", n, rise, ((n == 6) ? 2'b01 : 2'b00));
         end
      end
      in_raw = 2'b00;
      for (int k = 0; k < 8; k++) tick();
      total++; if (out_filt !== 2'b00) begin bad++; $display("FAIL lat_back got=%b want=00", out_filt); end
      total++; if (glitch_cnt !== 8'd0) begin bad++; $display("FAIL lat_gcnt got=%0d want=0", glitch_cnt); end
   endtask

   task automatic test_glitch();
      logic [1:0] seen;
      int         ri;
      int         fi;
      // 3-cycle pulse: rejected, counted once.
      seen   = 2'b00;
      in_raw = 2'b10;
      for (int k = 0; k < 3; k++) begin tick(); seen |= rise | fall; end
      in_raw = 2'b00;
      for (int k = 0; k < 8; k++) begin tick(); seen |= rise | fall; end
      total++; if (out_filt !== 2'b00) begin bad++; $display("FAIL g3_out got=%b want=00", out_filt); end
      total++; if (seen !== 2'b00) begin bad++; $display("FAIL g3_strobe got=%b want=00", seen); end
      total++; if (glitch_cnt !== 8'd1) begin bad++; $display("FAIL g3_gcnt got=%0d want=1", glitch_cnt); end
      // 4-cycle pulse: accepted, fall four cycles after rise.
      ri = -1;
      fi = -1;
      in_raw = 2'b10;
      for (int n = 1; n <= 16; n++) begin
         if (n == 5) in_raw = 2'b00;
         tick();
         if (rise[1] === 1'b1) ri = n;
         if (fall[1] === 1'b1) fi = n;
      end
      total++; if (ri !== 6) begin bad++; $display("FAIL g4_rise_edge got=%0d want=6", ri); end
      total++; if (fi !== 10) begin bad++; $display("FAIL g4_fall_edge got=%0d want=10", fi); end
      total++; if (glitch_cnt !== 8'd1) begin bad++; $display("FAIL g4_gcnt got=%0d want=1", glitch_cnt); end
   endtask

   task automatic test_both();
      in_raw = 2'b11;
      tick(); tick();
      in_raw = 2'b00;
      for (int k = 0; k < 8; k++) tick();
      total++; if (glitch_cnt !== 8'd3) begin bad++; $display("FAIL both_gcnt got=%0d want=3", glitch_cnt); end
      total++; if (out_filt !== 2'b00) begin bad++; $display("FAIL both_out got=%b want=00", out_filt); end
   endtask

   task automatic test_saturate();
      for (int k = 0; k < 100; k++) begin
         in_raw = 2'b01; tick();
         in_raw = 2'b00; tick();
      end
      for (int k = 0; k < 4; k++) tick();
      total++; if (glitch_cnt !== 8'd103) begin bad++; $display("FAIL sat_mid got=%0d want=103", glitch_cnt); end
      for (int k = 0; k < 200; k++) begin
         in_raw = 2'b01; tick();
         in_raw = 2'b00; tick();
      end
      for (int k = 0; k < 4; k++) tick();
      total++; if (glitch_cnt !== 8'd255) begin bad++; $display("FAIL sat_max got=%0d want=255", glitch_cnt); end
   endtask

   // Single-cycle pulse rejected on edge 4; clr_cnt asserted on that edge.
   task automatic test_clear();
      in_raw = 2'b01; tick();
      in_raw = 2'b00; tick(); tick();
      total++; if (glitch_cnt !== 8'd255) begin bad++; $display("FAIL clr_pre got=%0d want=255", glitch_cnt); end
      clr_cnt = 1'b1; tick();
      clr_cnt = 1'b0;
      total++; if (glitch_cnt !== 8'd0) begin bad++; $display("FAIL clr_edge got=%0d want=0", glitch_cnt); end
      in_raw = 2'b01; tick();
      in_raw = 2'b00;
      for (int k = 0; k < 4; k++) tick();
      total++; if (glitch_cnt !== 8'd1) begin bad++; $display("FAIL clr_after got=%0d want=1", glitch_cnt); end
   endtask

   task automatic test_enable();
      logic [1:0] seen;
      seen   = 2'b00;
      enable = 1'b0;
      in_raw = 2'b11;
      for (int k = 0; k < 10; k++) begin tick(); seen |= rise | fall; end
      total++; if (out_filt !== 2'b00) begin bad++; $display("FAIL en_hold got=%b want=00", out_filt); end
      total++; if (seen !== 2'b00) begin bad++; $display("FAIL en_strobe got=%b want=00", seen); end
      total++; if (glitch_cnt !== 8'd1) begin bad++; $display("FAIL en_gcnt got=%0d want=1", glitch_cnt); end
      enable = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         total++;
         if (out_filt !== ((n == 4) ? 2'b11 : 2'b00)) begin
            bad++; $display("FAIL en_requal e%0d got=%b want=%b", n, out_filt, ((n == 4) ? 2'b11 : 2'b00));
         end
      end
      total++; if (rise !== 2'b11) begin bad++; $display("FAIL en_rise got=%b want=11", rise); end
   endtask

   task automatic test_reset_midcount();
      logic [1:0] seen;
      // out_filt is 11; three qualifying edges toward 00, then reset.
      in_raw = 2'b00;
      for (int k = 0; k < 5; k++) tick();
      total++; if (out_filt !== 2'b11) begin bad++; $display("FAIL mid_pre got=%b want=11", out_filt); end
      rst_n = 1'b0;
      #1;
      total++; if (out_filt !== 2'b00) begin bad++; $display("FAIL mid_out got=%b want=00", out_filt); end
      total++; if (glitch_cnt !== 8'd0) begin bad++; $display("FAIL mid_gcnt got=%0d want=0", glitch_cnt); end
      tick(); tick();
      rst_n = 1'b1;
      seen  = 2'b00;
      for (int k = 0; k < 8; k++) begin tick(); seen |= rise | fall; end
      total++; if (seen !== 2'b00) begin bad++; $display("FAIL mid_strobe got=%b want=00", seen); end
      total++; if (glitch_cnt !== 8'd0) begin bad++; $display("FAIL mid_gcnt2 got=%0d want=0", glitch_cnt); end
      in_raw = 2'b01;
      for (int n = 1; n <= 6; n++) begin
         tick();
         total++;
         if (rise !== ((n == 6) ? 2'b01 : 2'b00)) begin
            bad++; $display("FAIL mid_requal e%0d got=%b want=%b", n, rise, ((n == 6) ? 2'b01 : 2'b00));
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_both();
      test_saturate();
      test_clear();
      test_enable();
      test_reset_midcount();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
